lh_msg_framer: RTL

//  Upstream framing stage for light_hash. Accepts a byte stream with end-of-message marker, buffers it
//  in a small FIFO, and drives light_hash's message_byte/message_valid/state inputs as one head pulse,
//  one pulse per message byte, and one tail pulse. Waits for digest_ready before the next message.

---
 rtl/lh_msg_framer.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/lh_msg_framer.sv
// lh_msg_framer: upstream framing stage for light_hash.
// Buffers an {in_last, in_byte} stream in a small FIFO and replays each message
// to light_hash as one head pulse, one pulse per byte and one tail pulse, with a
// minimum BYTE_GAP idle cycles between pulses. Frames longer than MAX_LEN are
// cut at MAX_LEN (len_err) and the remainder is discarded while waiting for the
// digest.
// Optional feature: define LH_FRAMER_PAD_EN to append 0x80 followed by 0x00
// padding bytes until the pulsed body length is a multiple of 8.
module lh_msg_framer #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned BYTE_GAP   = 2,
  parameter int unsigned MAX_LEN    = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_byte,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] message_byte,
  output logic       message_valid,
  output logic [1:0] state,
  input  logic       digest_ready,
  output logic       frame_done,
  output logic       len_err,
  output logic       busy
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned LW = (MAX_LEN > 1) ? $clog2(MAX_LEN + 1) : 1;
  localparam int unsigned GW = $clog2(BYTE_GAP + 1);

  localparam logic [1:0] ST_HEAD = 2'b00;
  localparam logic [1:0] ST_TAIL = 2'b01;
  localparam logic [1:0] ST_MSG  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEAD,
    S_BODY,
    S_TAIL,
    S_WAIT
`ifdef LH_FRAMER_PAD_EN
    ,
    S_PAD
`endif
  } fsm_e;

  // State entered after the final body pulse (last byte or truncation).
`ifdef LH_FRAMER_PAD_EN
  localparam fsm_e S_POST_BODY = S_PAD;
`else
  localparam fsm_e S_POST_BODY = S_TAIL;
`endif

  // FIFO storage and bookkeeping
  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push;
  logic          pop;
  logic [8:0]    rd_entry;

  // Framing control
  fsm_e          fsm_q, fsm_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] len_inc;
  logic          drop_q, drop_d;
  logic          dig_seen_q, dig_seen_d;
`ifdef LH_FRAMER_PAD_EN
  logic [2:0]    pad_mod_q, pad_mod_d;
  logic          pad_first_q, pad_first_d;
`endif

  // Registered outputs
  logic          message_valid_q, message_valid_d;
  logic [7:0]    message_byte_q, message_byte_d;
  logic [1:0]    msg_state_q, msg_state_d;
  logic          frame_done_q, frame_done_d;
  logic          len_err_q, len_err_d;
  logic          busy_q, busy_d;

  // Readiness uses the registered count only: a same-cycle pop never frees a slot.
  assign in_ready      = (count_q != CW'(FIFO_DEPTH));
  assign push          = in_valid & in_ready;
  assign rd_entry      = mem_q[rd_ptr_q];

  assign message_valid = message_valid_q;
  assign message_byte  = message_byte_q;
  assign state         = msg_state_q;
  assign frame_done    = frame_done_q;
  assign len_err       = len_err_q;
  assign busy          = busy_q;

  // FIFO storage write; contents need no reset, pointers/count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_last, in_byte};
    end
  end

  // Next-state logic: framing FSM, pulse generation, drop of truncated tails.
  always_comb begin
    fsm_d           = fsm_q;
    gap_d           = gap_q;
    if (gap_q != '0) begin
      gap_d = gap_q - GW'(1);
    end
    len_d           = len_q;
    len_inc         = len_q + LW'(1);
    drop_d          = drop_q;
    dig_seen_d      = dig_seen_q;
    message_valid_d = 1'b0;
    message_byte_d  = message_byte_q;
    msg_state_d     = msg_state_q;
    frame_done_d    = 1'b0;
    len_err_d       = len_err_q;
    pop             = 1'b0;
`ifdef LH_FRAMER_PAD_EN
    pad_mod_d       = pad_mod_q;
    pad_first_d     = pad_first_q;
`endif

    case (fsm_q)
      S_IDLE: begin
        if (count_q != '0) begin
          fsm_d = S_HEAD;
        end
      end

      S_HEAD: begin
        if (gap_q == '0) begin
          message_valid_d = 1'b1;
          msg_state_d     = ST_HEAD;
          message_byte_d  = '0;
          gap_d           = GW'(BYTE_GAP);
          len_d           = '0;
          len_err_d       = 1'b0;
          dig_seen_d      = 1'b0;
`ifdef LH_FRAMER_PAD_EN
          pad_mod_d       = '0;
          pad_first_d     = 1'b1;
`endif
          fsm_d           = S_BODY;
        end
      end

      S_BODY: begin
        if ((gap_q == '0) && (count_q != '0)) begin
          pop             = 1'b1;
          message_valid_d = 1'b1;
          msg_state_d     = ST_MSG;
          message_byte_d  = rd_entry[7:0];
          gap_d           = GW'(BYTE_GAP);
          len_d           = len_inc;
`ifdef LH_FRAMER_PAD_EN
          pad_mod_d       = pad_mod_q + 3'd1;
`endif
          if (rd_entry[8]) begin
            fsm_d = S_POST_BODY;
          end else if (len_inc == LW'(MAX_LEN)) begin
            // Truncate: finish the frame now, discard the rest while in WAIT.
            len_err_d = 1'b1;
            drop_d    = 1'b1;
            fsm_d     = S_POST_BODY;
          end
        end
      end

`ifdef LH_FRAMER_PAD_EN
      S_PAD: begin
        if (gap_q == '0) begin
          message_valid_d = 1'b1;
          msg_state_d     = ST_MSG;
          message_byte_d  = pad_first_q ? 8'h80 : 8'h00;
          gap_d           = GW'(BYTE_GAP);
          pad_first_d     = 1'b0;
          pad_mod_d       = pad_mod_q + 3'd1;
          if (pad_mod_q == 3'd7) begin
            fsm_d = S_TAIL;
          end
        end
      end
`endif

      S_TAIL: begin
        if (gap_q == '0) begin
          message_valid_d = 1'b1;
          msg_state_d     = ST_TAIL;
          message_byte_d  = '0;
          gap_d           = GW'(BYTE_GAP);
          dig_seen_d      = 1'b0;
          fsm_d           = S_WAIT;
        end
      end

      S_WAIT: begin
        // Discard leftover bytes of a truncated frame up to its last marker.
        if (drop_q && (count_q != '0)) begin
          pop = 1'b1;
          if (rd_entry[8]) begin
            drop_d = 1'b0;
          end
        end
        // A digest arriving while still dropping is remembered, not lost.
        if (digest_ready) begin
          dig_seen_d = 1'b1;
        end
        if ((digest_ready || dig_seen_q) && !drop_q) begin
          frame_done_d = 1'b1;
          dig_seen_d   = 1'b0;
          fsm_d        = S_IDLE;
        end
      end

      default: begin
        fsm_d = S_IDLE;
      end
    endcase

    wr_ptr_d = push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    busy_d   = (fsm_d != S_IDLE);
  end

  // State registers with synchronous reset; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q           <= S_IDLE;
      gap_q           <= '0;
      len_q           <= '0;
      drop_q          <= 1'b0;
      dig_seen_q      <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      message_valid_q <= 1'b0;
      message_byte_q  <= '0;
      msg_state_q     <= ST_HEAD;
      frame_done_q    <= 1'b0;
      len_err_q       <= 1'b0;
      busy_q          <= 1'b0;
`ifdef LH_FRAMER_PAD_EN
      pad_mod_q       <= '0;
      pad_first_q     <= 1'b0;
`endif
    end else begin
      fsm_q           <= fsm_d;
      gap_q           <= gap_d;
      len_q           <= len_d;
      drop_q          <= drop_d;
      dig_seen_q      <= dig_seen_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      message_valid_q <= message_valid_d;
      message_byte_q  <= message_byte_d;
      msg_state_q     <= msg_state_d;
      frame_done_q    <= frame_done_d;
      len_err_q       <= len_err_d;
      busy_q          <= busy_d;
`ifdef LH_FRAMER_PAD_EN
      pad_mod_q       <= pad_mod_d;
      pad_first_q     <= pad_first_d;
`endif
    end
  end

endmodule
